mdu_param: RTL

- Parametrised multi-cycle multiply/divide unit for the 5-stage MIPS pipeline; sits in stage E beside the ALU.
- Generalises the current fixed-width MDU with:
  - configurable data width and per-class latency;
  - multiply-accumulate ops (madd/maddu/msub/msubu);
  - exception abort: an in-flight operation is cancelled on `req` and HI/LO are left untouched.
- Supplies the busy signal the hazard unit uses for md/mf/mt stalls.

---
 rtl/mdu_param_if.sv | 38 +++
 rtl/mdu_param.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_param_if.sv
// ----------------------------------------------------------------------------
// mdu_param_if
// Bundles the request and result signals of the multiply/divide unit so the
// pipeline stage (master) and the MDU (slave) share one connection.
//
// Signals:
//   req     exception/interrupt request from CP0 (aborts or blocks operations)
//   start   one-cycle pulse launching a multi-cycle operation
//   mdu_op  operation code (mult, multu, div, divu, mfhi, mflo, mthi, mtlo,
//           madd, maddu, msub, msubu)
//   a, b    forwarded rs / rt operands
//   hi, lo  architectural HI / LO registers
//   out     mfhi/mflo read data, zero for any other opcode
//   busy    a multi-cycle operation is in flight
// ----------------------------------------------------------------------------
interface mdu_param_if #(
    parameter int WIDTH = 32
);
    logic             req;
    logic             start;
    logic [3:0]       mdu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] out;
    logic             busy;

    modport master (
        output req, start, mdu_op, a, b,
        input  hi, lo, out, busy
    );

    modport slave (
        input  req, start, mdu_op, a, b,
        output hi, lo, out, busy
    );
endinterface

// File: rtl/mdu_param.sv
// ----------------------------------------------------------------------------
// mdu_param
// Parametrised multi-cycle multiply/divide unit for the E stage of the MIPS
// pipeline. The full result is computed at the launch edge and parked in
// pending registers. It is committed to HI/LO once the programmed latency has
// elapsed, unless a CP0 request aborts the operation first.
//
// Parameters:
//   WIDTH        operand and HI/LO width (even, >= 8)
//   MULT_CYCLES  busy cycles for mult/multu/madd/maddu/msub/msubu (>= 1)
//   DIV_CYCLES   busy cycles for div/divu (>= 1)
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    mdu_param_if slave modport (req, start, mdu_op, a, b -> hi, lo,
//          out, busy)
// ----------------------------------------------------------------------------
module mdu_param #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    mdu_param_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] pend_hi;
    logic [WIDTH-1:0] pend_lo;

    logic             is_mul_op;
    logic             is_div_op;
    logic             launch;
    logic             commit;
    logic             write_hi;
    logic             write_lo;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH-1:0]   udivisor;
    logic [WIDTH-1:0]   sdivisor;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   quot_u;
    logic [WIDTH-1:0]   rem_u;
    logic               b_zero;
    logic               div_ovf;

    assign is_mul_op = (bus.mdu_op == OP_MULT)  || (bus.mdu_op == OP_MULTU) ||
                       (bus.mdu_op == OP_MADD)  || (bus.mdu_op == OP_MADDU) ||
                       (bus.mdu_op == OP_MSUB)  || (bus.mdu_op == OP_MSUBU);
    assign is_div_op = (bus.mdu_op == OP_DIV) || (bus.mdu_op == OP_DIVU);

    // Next-state and control decode. A CP0 request wins over everything:
    // it blocks launches and mt writes in IDLE and aborts a running op.
    // start is ignored while RUN, so back-to-back launches cannot occur.
    always_comb begin
        next_state = state;
        launch     = 1'b0;
        commit     = 1'b0;
        write_hi   = 1'b0;
        write_lo   = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.req) begin
                    if (bus.start && (is_mul_op || is_div_op)) begin
                        launch     = 1'b1;
                        next_state = RUN;
                    end
                    write_hi = (bus.mdu_op == OP_MTHI);
                    write_lo = (bus.mdu_op == OP_MTLO);
                end
            end
            RUN: begin
                if (bus.req) begin
                    next_state = IDLE;
                end else if (counter == '0) begin
                    commit     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Full-width arithmetic evaluated from the operands and current HI/LO at
    // the launch edge. The signed divisor is forced to 1 both for a zero
    // divisor (guarded below) and for MOST_NEG / -1, where a / 1 yields the
    // required quotient MOST_NEG with remainder 0 without an overflowing
    // divide.
    always_comb begin
        acc      = {hi_q, lo_q};
        prod_s   = $unsigned($signed({{WIDTH{bus.a[WIDTH-1]}}, bus.a}) *
                             $signed({{WIDTH{bus.b[WIDTH-1]}}, bus.b}));
        prod_u   = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
        b_zero   = (bus.b == '0);
        div_ovf  = (bus.a == MOST_NEG) && (bus.b == '1);
        udivisor = b_zero ? ONE : bus.b;
        sdivisor = (b_zero || div_ovf) ? ONE : bus.b;
        quot_u   = bus.a / udivisor;
        rem_u    = bus.a % udivisor;
        quot_s   = $unsigned($signed(bus.a) / $signed(sdivisor));
        rem_s    = $unsigned($signed(bus.a) % $signed(sdivisor));
        result   = acc;
        case (bus.mdu_op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_MADD:  result = acc + prod_s;
            OP_MADDU: result = acc + prod_u;
            OP_MSUB:  result = acc - prod_s;
            OP_MSUBU: result = acc - prod_u;
            OP_DIV:   result = b_zero ? acc : {rem_s, quot_s};
            OP_DIVU:  result = b_zero ? acc : {rem_u, quot_u};
            default:  result = acc;
        endcase
    end

    // State, latency counter and pending result. The counter loads N-1 so
    // the commit edge falls exactly N cycles after launch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            counter <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else begin
            state <= next_state;
            if (launch) begin
                counter <= is_div_op ? DIV_LOAD : MULT_LOAD;
                pend_hi <= result[2*WIDTH-1:WIDTH];
                pend_lo <= result[WIDTH-1:0];
            end else if ((state == RUN) && !bus.req && (counter != '0)) begin
                counter <= counter - CNT_W'(1);
            end
        end
    end

    // Architectural HI/LO. Commit only happens in RUN and mt writes only in
    // IDLE, so the two update sources never coincide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (commit) begin
                hi_q <= pend_hi;
                lo_q <= pend_lo;
            end
            if (write_hi) begin
                hi_q <= bus.a;
            end
            if (write_lo) begin
                lo_q <= bus.a;
            end
        end
    end

    // Read port is purely combinational and may return stale HI/LO while an
    // op is in flight; the hazard unit stalls mfhi/mflo on busy.
    always_comb begin
        bus.out = '0;
        if (bus.mdu_op == OP_MFHI) begin
            bus.out = hi_q;
        end else if (bus.mdu_op == OP_MFLO) begin
            bus.out = lo_q;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state == RUN);

endmodule
